lsu_mem_port: RTL and testbench

Parametrised load/store unit between the core's execute stage and the DPI-backed physical memory. It replaces the single-cycle store-only path (`sd` with a fixed address/data pair and a zero write mask) with a multi-cycle engine. The engine handles every RISC-V load/store size, does sign/zero extension, generates byte-lane masks and checks alignment. It uses a valid/ready handshake toward the core and a request/grant/response handshake toward memory, so memory latency is no longer fixed.

---
 rtl/lsu_mem_port.sv | 163 ++++++++++++++++
 tb/tb_lsu_mem_port.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store unit bridging the execute stage (valid/ready) to the physical memory port
// (request/grant/response). Handles all access sizes, lane masks, extension and alignment faults.
//
// state | meaning
// IDLE  | ready for a new access; faults go straight to RESP
// REQ   | memory request driven and held until mem_gnt
// WAIT  | load granted, waiting for mem_rvalid
// RESP  | one-cycle completion pulse toward the core
module lsu_mem_port #(
  parameter int XLEN = 64,
  parameter int NB   = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misalign,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [NB-1:0]   mem_wmask,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t state_q, state_d;

  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            mis_q;

  logic [OFFW-1:0] req_off;
  logic [OFFW-1:0] off_q;
  logic [2:0]      align_mask;
  logic            fault;

  logic [NB-1:0]   lane_mask;
  logic [NB-1:0]   store_mask;
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] rd_ext;
  logic            sign_bit;
  logic            in_req;

  assign req_off = req_addr[OFFW-1:0];
  assign off_q   = addr_q[OFFW-1:0];

  always_comb begin
    case (req_size)
      2'd0:    align_mask = 3'd0;
      2'd1:    align_mask = 3'd1;
      2'd2:    align_mask = 3'd3;
      default: align_mask = 3'd7;
    endcase
    fault = ((3'(req_off) & align_mask) != 3'd0) || ((req_size == 2'd3) && (XLEN == 32));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = fault ? RESP : REQ;
      REQ:  if (mem_gnt) state_d = we_q ? RESP : WAIT;
      WAIT: if (mem_rvalid) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Load extraction: move the addressed bytes to lane 0, then extend above the access width.
  always_comb begin
    rd_shift = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    sign_bit = rd_shift[7];
      2'd1:    sign_bit = rd_shift[15];
      2'd2:    sign_bit = rd_shift[31];
      default: sign_bit = rd_shift[XLEN-1];
    endcase
    if (uns_q) sign_bit = 1'b0;
    rd_ext = '0;
    for (int i = 0; i < XLEN; i++) begin
      rd_ext[i] = (i < (8 << size_q)) ? rd_shift[i] : sign_bit;
    end
  end

  // Result registers only change on entry to RESP so the previous response stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          if (fault) begin
            rdata_q <= '0;
            mis_q   <= 1'b1;
          end
        end
        REQ: if (mem_gnt && we_q) begin
          rdata_q <= '0;
          mis_q   <= 1'b0;
        end
        WAIT: if (mem_rvalid) begin
          rdata_q <= rd_ext;
          mis_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NB; i++) begin
      lane_mask[i] = (i < (1 << size_q));
    end
    store_mask = lane_mask << off_q;
  end

  // Outputs are forced to their reset values while rst is high, whatever the state.
  assign in_req        = (state_q == REQ) && !rst;
  assign mem_req       = in_req;
  assign mem_we        = in_req && we_q;
  assign mem_addr      = in_req ? {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
  assign mem_wdata     = in_req ? (wdata_q << {off_q, 3'b000}) : '0;
  assign mem_wmask     = in_req ? (we_q ? store_mask : '1) : '0;

  assign req_ready     = (state_q == IDLE) || rst;
  assign resp_valid    = (state_q == RESP) && !rst;
  assign resp_rdata    = rst ? '0 : rdata_q;
  assign resp_misalign = mis_q && !rst;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port (XLEN = 64): a vector table of single accesses with
// grant/data delays, plus hand-written sequences for reset and response-ordering corners.
module tb_lsu_mem_port;

  localparam int XLEN = 64;
  localparam int NB   = XLEN / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_misalign;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [NB-1:0]   mem_wmask;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  lsu_mem_port #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          gd;      // cycles without grant
    int          rd;      // WAIT cycles without rvalid
    logic [63:0] e_addr;
    logic [7:0]  e_mask;
    logic [63:0] e_wdata;
    logic [63:0] e_rdata;
    logic        e_mis;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_req_ready"},  64'(req_ready), 64'd1);
    chk({pfx, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({pfx, "_resp_rdata"}, resp_rdata, 64'd0);
    chk({pfx, "_resp_mis"},   64'(resp_misalign), 64'd0);
    chk({pfx, "_mem_ctl"},    {54'd0, mem_req, mem_we, mem_wmask}, 64'd0);
    chk({pfx, "_mem_addr"},   mem_addr, 64'd0);
    chk({pfx, "_mem_wdata"},  mem_wdata, 64'd0);
  endtask

  task automatic do_access(input vec_t v);
    logic [63:0] c_addr, c_wdata, c_rdata;
    logic [7:0]  c_mask;
    logic        c_we, c_mis;
    int          resp_cyc, exp_lat, gcnt, rcnt;
    bit          saw_req, unstable, ready_bad, granted;
    c_addr = '0; c_wdata = '0; c_rdata = '0; c_mask = '0; c_we = 1'b0; c_mis = 1'b0;
    resp_cyc = -1; gcnt = 0; rcnt = 0;
    saw_req = 1'b0; unstable = 1'b0; ready_bad = 1'b0; granted = 1'b0;
    exp_lat = v.e_mis ? 1 : (v.we ? 2 + v.gd : 3 + v.gd + v.rd);

    chk({v.name, "_ready_idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    tick();
    req_valid = 1'b0; req_wdata = 64'hA5A5_A5A5_A5A5_A5A5; req_addr = 64'hFFFF_FFFF_FFFF_FFFF;

    for (int cyc = 1; cyc < 60 && resp_cyc < 0; cyc++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (req_ready) ready_bad = 1'b1;
      if (mem_req) begin
        if (!saw_req) begin
          saw_req = 1'b1;
          c_addr = mem_addr; c_wdata = mem_wdata; c_mask = mem_wmask; c_we = mem_we;
        end else if (mem_addr !== c_addr || mem_wdata !== c_wdata ||
                     mem_wmask !== c_mask || mem_we !== c_we) begin
          unstable = 1'b1;
        end
        if (gcnt == v.gd) begin
          mem_gnt = 1'b1;
          granted = 1'b1;
        end
        gcnt++;
      end else if (granted && !v.we && !resp_valid) begin
        if (rcnt == v.rd) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.rdata;
        end
        rcnt++;
      end
      if (resp_valid) begin
        resp_cyc = cyc;
        c_rdata  = resp_rdata;
        c_mis    = resp_misalign;
      end
      tick();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    chk({v.name, "_latency"},   64'(resp_cyc), 64'(exp_lat));
    chk({v.name, "_rdata"},     c_rdata, v.e_rdata);
    chk({v.name, "_misalign"},  64'(c_mis), 64'(v.e_mis));
    chk({v.name, "_ready_busy"}, 64'(ready_bad), 64'd0);
    chk({v.name, "_ready_after"}, 64'(req_ready), 64'd1);
    chk({v.name, "_resp_pulse"}, 64'(resp_valid), 64'd0);
    chk({v.name, "_idle_mem"},  {54'd0, mem_req, mem_we, mem_wmask}, 64'd0);
    if (v.e_mis) begin
      chk({v.name, "_no_req"}, 64'(saw_req), 64'd0);
    end else begin
      chk({v.name, "_mem_addr"},  c_addr, v.e_addr);
      chk({v.name, "_mem_wmask"}, 64'(c_mask), 64'(v.e_mask));
      chk({v.name, "_mem_wdata"}, c_wdata, v.e_wdata);
      chk({v.name, "_mem_we"},    64'(c_we), 64'(v.we));
      chk({v.name, "_stable"},    64'(unstable), 64'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t lbu;
    bit   saw_resp;

    //        name         we    sz    uns   addr                    wdata                   rdata                   gd rd e_addr                  mask   e_wdata                 e_rdata                 mis
    vecs[0]  = '{"sb",      1'b1, 2'd0, 1'b0, 64'h8000_0003,          64'hAB,                 64'h0,                  0, 0, 64'h8000_0000,          8'h08, 64'h0000_0000_AB00_0000, 64'h0,                  1'b0};
    vecs[1]  = '{"lh",      1'b0, 2'd1, 1'b0, 64'h8000_0006,          64'h0,                  64'h8001_2233_4455_6677, 0, 0, 64'h8000_0000,          8'hFF, 64'h0,                  64'hFFFF_FFFF_FFFF_8001, 1'b0};
    vecs[2]  = '{"lhu",     1'b0, 2'd1, 1'b1, 64'h8000_0006,          64'h0,                  64'h8001_2233_4455_6677, 0, 0, 64'h8000_0000,          8'hFF, 64'h0,                  64'h0000_0000_0000_8001, 1'b0};
    vecs[3]  = '{"lw_mis",  1'b0, 2'd2, 1'b0, 64'h8000_0002,          64'h0,                  64'h0,                  0, 0, 64'h0,                  8'h00, 64'h0,                  64'h0,                  1'b1};
    vecs[4]  = '{"sd_bp",   1'b1, 2'd3, 1'b0, 64'h8000_0008,          64'h1122_3344_5566_7788, 64'h0,                  3, 0, 64'h8000_0008,          8'hFF, 64'h1122_3344_5566_7788, 64'h0,                  1'b0};
    vecs[5]  = '{"ld_late", 1'b0, 2'd3, 1'b0, 64'h8000_0010,          64'h0,                  64'hDEAD_BEEF_CAFE_F00D, 0, 3, 64'h8000_0010,          8'hFF, 64'h0,                  64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    vecs[6]  = '{"lb",      1'b0, 2'd0, 1'b0, 64'h8000_0005,          64'h0,                  64'h0000_9A00_0000_0000, 0, 0, 64'h8000_0000,          8'hFF, 64'h0,                  64'hFFFF_FFFF_FFFF_FF9A, 1'b0};
    vecs[7]  = '{"lw",      1'b0, 2'd2, 1'b0, 64'h8000_0004,          64'h0,                  64'h8765_4321_0000_0000, 0, 0, 64'h8000_0000,          8'hFF, 64'h0,                  64'hFFFF_FFFF_8765_4321, 1'b0};
    vecs[8]  = '{"lwu",     1'b0, 2'd2, 1'b1, 64'h8000_0004,          64'h0,                  64'h8765_4321_0000_0000, 1, 1, 64'h8000_0000,          8'hFF, 64'h0,                  64'h0000_0000_8765_4321, 1'b0};
    vecs[9]  = '{"sh",      1'b1, 2'd1, 1'b0, 64'h8000_000A,          64'hBEEF,               64'h0,                  0, 0, 64'h8000_0008,          8'h0C, 64'h0000_0000_BEEF_0000, 64'h0,                  1'b0};
    vecs[10] = '{"sw",      1'b1, 2'd2, 1'b0, 64'h8000_0004,          64'h1234_5678,          64'h0,                  1, 0, 64'h8000_0000,          8'hF0, 64'h1234_5678_0000_0000, 64'h0,                  1'b0};
    vecs[11] = '{"sh_mis",  1'b1, 2'd1, 1'b0, 64'h8000_0001,          64'hFFFF,               64'h0,                  0, 0, 64'h0,                  8'h00, 64'h0,                  64'h0,                  1'b1};
    vecs[12] = '{"sd_mis",  1'b1, 2'd3, 1'b0, 64'h8000_0004,          64'h1,                  64'h0,                  0, 0, 64'h0,                  8'h00, 64'h0,                  64'h0,                  1'b1};
    vecs[13] = '{"ld_uns",  1'b0, 2'd3, 1'b1, 64'h8000_0018,          64'h0,                  64'hF000_0000_0000_0001, 0, 0, 64'h8000_0018,          8'hFF, 64'h0,                  64'hF000_0000_0000_0001, 1'b0};
    vecs[14] = '{"sb_clr",  1'b1, 2'd0, 1'b0, 64'h8000_0000,          64'h55,                 64'h0,                  0, 0, 64'h8000_0000,          8'h01, 64'h0000_0000_0000_0055, 64'h0,                  1'b0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
    tick();
    chk_reset_outs("rst_high");
    rst = 1'b0;
    tick();
    chk_reset_outs("rst_after");

    for (int i = 0; i < 15; i++) do_access(vecs[i]);

    // rvalid in IDLE is ignored; grant and rvalid together in REQ only honour the grant
    mem_rvalid = 1'b1; mem_rdata = 64'h77;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    chk("idle_rvalid_ignored", {62'd0, resp_valid, req_ready}, 64'd1);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b1; req_addr = 64'h8000_0000;
    tick();
    req_valid = 1'b0;
    chk("gr_req", 64'(mem_req), 64'd1);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h11;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    chk("gr_no_early_resp", {62'd0, resp_valid, mem_req}, 64'd0);
    tick();
    chk("gr_still_wait", {62'd0, resp_valid, req_ready}, 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'h22;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    chk("gr_resp_valid", 64'(resp_valid), 64'd1);
    chk("gr_resp_rdata", resp_rdata, 64'h22);
    tick();
    chk("gr_ready_after", 64'(req_ready), 64'd1);

    // reset while a load sits in WAIT
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'h8000_0010;
    tick();
    req_valid = 1'b0;
    chk("rl_req", 64'(mem_req), 64'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rl_in_wait", {62'd0, req_ready, mem_req}, 64'd0);
    rst = 1'b1;
    #1;
    chk_reset_outs("rl_rst_high");
    tick();
    rst = 1'b0;
    chk_reset_outs("rl_rst_after");
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_1111;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    saw_resp = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (resp_valid || !req_ready) saw_resp = 1'b1;
      tick();
    end
    chk("rl_no_resp", 64'(saw_resp), 64'd0);

    lbu = '{"lbu_post_rst", 1'b0, 2'd0, 1'b1, 64'h8000_0001, 64'h0, 64'h0000_0000_0000_80FF,
            0, 0, 64'h8000_0000, 8'hFF, 64'h0, 64'h0000_0000_0000_0080, 1'b0};
    do_access(lbu);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
